// File: rtl/timer_controller.sv
// timer_controller
// Sequencing core for the timer peripheral. It takes the enable, one-shot,
// reload-count and interrupt-clear fields from the register block. It runs a
// prescaled down-counter through load, run, expire and reload phases. It also
// returns a sticky expiry flag and status back to the register block.
//
// Ports:
//   clk                    system clock, rising edge
//   reset                  synchronous active-high reset
//   timer_enable           run request (level)
//   timer_one_shot         1 = stop after first expiry, 0 = periodic reload
//   timer_count            reload value in ticks
//   timer_interrupt_clear  clears the sticky expiry flag while high
//   timer_interrupt        sticky expiry flag
//   timer_running          high while in RUN
//   timer_value            current down-counter value
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for timer_enable, timer_value holds last value
// LOAD  | one cycle: load timer_count, clear prescaler
// RUN   | counting ticks, reload on expiry in periodic mode
// DONE  | one-shot expired or zero count; wait for enable low to re-arm

module timer_controller #(
   parameter int WIDTH    = 32,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             timer_enable,
   input  logic             timer_one_shot,
   input  logic [WIDTH-1:0] timer_count,
   input  logic             timer_interrupt_clear,
   output logic             timer_interrupt,
   output logic             timer_running,
   output logic [WIDTH-1:0] timer_value
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t state;
   logic [PW-1:0] prescaler;
   logic tick;
   logic expire;

   assign tick = (prescaler == PRE_LAST);
   // Disable outranks a tick on the same cycle, so an expiry needs enable high.
   assign expire = (state == RUN) && timer_enable && tick && (timer_value == ONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         prescaler       <= '0;
         timer_interrupt <= 1'b0;
         timer_running   <= 1'b0;
         timer_value     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (timer_enable) state <= LOAD;
            end
            LOAD: begin
               timer_value <= timer_count;
               prescaler   <= '0;
               if (timer_count == '0) begin
                  state <= DONE;
               end else begin
                  state         <= RUN;
                  timer_running <= 1'b1;
               end
            end
            RUN: begin
               if (!timer_enable) begin
                  state         <= IDLE;
                  prescaler     <= '0;
                  timer_running <= 1'b0;
               end else begin
                  prescaler <= tick ? '0 : prescaler + PW'(1);
                  if (tick && timer_value > ONE) begin
                     timer_value <= timer_value - ONE;
                  end else if (expire) begin
                     if (timer_one_shot) begin
                        timer_value   <= '0;
                        state         <= DONE;
                        timer_running <= 1'b0;
                     end else begin
                        timer_value <= timer_count;
                        // A zero reload could never expire again; park in DONE
                        // instead of sitting in RUN forever.
                        if (timer_count == '0) begin
                           state         <= DONE;
                           timer_running <= 1'b0;
                        end
                     end
                  end
               end
            end
            DONE: begin
               if (!timer_enable) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Set beats clear so an expiry coinciding with a clear is not lost.
         if (expire)                     timer_interrupt <= 1'b1;
         else if (timer_interrupt_clear) timer_interrupt <= 1'b0;
      end
   end

endmodule

// File: tb/tb_timer_controller.sv
module tb_timer_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        timer_enable = 1'b0;
   logic        timer_one_shot = 1'b0;
   logic [31:0] timer_count = '0;
   logic        timer_interrupt_clear = 1'b0;

   logic        irq, run;
   logic [31:0] val;
   logic        p_irq, p_run;
   logic [31:0] p_val;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst, en, os, clr;
      logic [31:0] cnt;
      logic        irq, run;
      logic [31:0] val;
   } step_t;

   step_t q[$];

   always #5 clk = ~clk;

   timer_controller #(.WIDTH(32), .PRESCALE(1)) dut (
      .clk(clk), .reset(reset), .timer_enable(timer_enable),
      .timer_one_shot(timer_one_shot), .timer_count(timer_count),
      .timer_interrupt_clear(timer_interrupt_clear),
      .timer_interrupt(irq), .timer_running(run), .timer_value(val));

   timer_controller #(.WIDTH(32), .PRESCALE(3)) dut_p3 (
      .clk(clk), .reset(reset), .timer_enable(timer_enable),
      .timer_one_shot(timer_one_shot), .timer_count(timer_count),
      .timer_interrupt_clear(timer_interrupt_clear),
      .timer_interrupt(p_irq), .timer_running(p_run), .timer_value(p_val));

   // Each entry: inputs for one cycle, then the outputs expected after that edge.
   function automatic void push(logic rst, logic en, logic os, logic clr, logic [31:0] cnt,
                                logic e_irq, logic e_run, logic [31:0] e_val);
      step_t s;
      s.rst = rst; s.en = en; s.os = os; s.clr = clr; s.cnt = cnt;
      s.irq = e_irq; s.run = e_run; s.val = e_val;
      q.push_back(s);
   endfunction

   task automatic test_reset();
      step_t s;
      int k = 0;
      push(1,0,0,0,0,  0,0,0);
      push(0,0,0,0,0,  0,0,0);
      push(0,0,0,0,0,  0,0,0);
      push(0,1,0,0,7,  0,0,0);
      push(0,1,0,0,7,  0,1,7);
      push(1,1,0,0,7,  0,0,0);
      push(0,0,0,0,7,  0,0,0);
      while (q.size() > 0) begin
         s = q.pop_front();
         reset = s.rst; timer_enable = s.en; timer_one_shot = s.os;
         timer_interrupt_clear = s.clr; timer_count = s.cnt;
         @(posedge clk); #1;
         n_checks++;
         if ({irq, run, val} !== {s.irq, s.run, s.val}) begin
            n_fail++;
            $display("FAIL reset step %0d: irq/run/value got %b/%b/%h expected %b/%b/%h",
                     k, irq, run, val, s.irq, s.run, s.val);
         end
         k++;
      end
   endtask

   task automatic test_one_shot();
      step_t s;
      int k = 0;
      push(0,1,1,0,3,  0,0,0);
      push(0,1,1,0,3,  0,1,3);
      push(0,1,1,0,3,  0,1,2);
      push(0,1,1,0,3,  0,1,1);
      push(0,1,1,0,3,  1,0,0);
      push(0,1,1,0,3,  1,0,0);
      push(0,0,1,0,3,  1,0,0);
      push(0,1,1,1,3,  0,0,0);
      push(0,1,1,0,3,  0,1,3);
      push(0,1,1,0,3,  0,1,2);
      push(0,1,1,0,3,  0,1,1);
      push(0,1,1,0,3,  1,0,0);
      push(0,0,1,1,3,  0,0,0);
      while (q.size() > 0) begin
         s = q.pop_front();
         reset = s.rst; timer_enable = s.en; timer_one_shot = s.os;
         timer_interrupt_clear = s.clr; timer_count = s.cnt;
         @(posedge clk); #1;
         n_checks++;
         if ({irq, run, val} !== {s.irq, s.run, s.val}) begin
            n_fail++;
            $display("FAIL one_shot step %0d: irq/run/value got %b/%b/%h expected %b/%b/%h",
                     k, irq, run, val, s.irq, s.run, s.val);
         end
         k++;
      end
   endtask

   task automatic test_periodic();
      step_t s;
      int k = 0;
      push(0,1,0,0,4,  0,0,0);
      push(0,1,0,0,4,  0,1,4);
      push(0,1,0,0,4,  0,1,3);
      push(0,1,0,0,4,  0,1,2);
      push(0,1,0,0,4,  0,1,1);
      push(0,1,0,0,4,  1,1,4);
      push(0,1,0,1,4,  0,1,3);
      push(0,1,0,0,4,  0,1,2);
      push(0,1,0,0,4,  0,1,1);
      push(0,1,0,1,4,  1,1,4);
      push(0,1,0,1,4,  0,1,3);
      push(0,1,0,0,9,  0,1,2);
      push(0,1,0,0,9,  0,1,1);
      push(0,1,0,0,9,  1,1,9);
      push(0,1,0,0,9,  1,1,8);
      push(0,1,0,0,9,  1,1,7);
      push(0,1,0,0,9,  1,1,6);
      push(0,1,0,0,9,  1,1,5);
      push(0,0,0,0,9,  1,0,5);
      push(0,0,0,0,9,  1,0,5);
      push(0,0,0,1,9,  0,0,5);
      while (q.size() > 0) begin
         s = q.pop_front();
         reset = s.rst; timer_enable = s.en; timer_one_shot = s.os;
         timer_interrupt_clear = s.clr; timer_count = s.cnt;
         @(posedge clk); #1;
         n_checks++;
         if ({irq, run, val} !== {s.irq, s.run, s.val}) begin
            n_fail++;
            $display("FAIL periodic step %0d: irq/run/value got %b/%b/%h expected %b/%b/%h",
                     k, irq, run, val, s.irq, s.run, s.val);
         end
         k++;
      end
   endtask

   task automatic test_zero_count();
      step_t s;
      int k = 0;
      push(0,1,0,0,0,  0,0,5);
      push(0,1,0,0,0,  0,0,0);
      push(0,1,0,0,0,  0,0,0);
      push(0,0,0,0,0,  0,0,0);
      while (q.size() > 0) begin
         s = q.pop_front();
         reset = s.rst; timer_enable = s.en; timer_one_shot = s.os;
         timer_interrupt_clear = s.clr; timer_count = s.cnt;
         @(posedge clk); #1;
         n_checks++;
         if ({irq, run, val} !== {s.irq, s.run, s.val}) begin
            n_fail++;
            $display("FAIL zero_count step %0d: irq/run/value got %b/%b/%h expected %b/%b/%h",
                     k, irq, run, val, s.irq, s.run, s.val);
         end
         k++;
      end
   endtask

   task automatic test_max_count();
      step_t s;
      int k = 0;
      push(0,1,0,0,32'hFFFF_FFFF,  0,0,32'h0000_0000);
      push(0,1,0,0,32'hFFFF_FFFF,  0,1,32'hFFFF_FFFF);
      push(0,1,0,0,32'hFFFF_FFFF,  0,1,32'hFFFF_FFFE);
      push(0,0,0,0,32'hFFFF_FFFF,  0,0,32'hFFFF_FFFE);
      push(0,0,0,0,32'hFFFF_FFFF,  0,0,32'hFFFF_FFFE);
      while (q.size() > 0) begin
         s = q.pop_front();
         reset = s.rst; timer_enable = s.en; timer_one_shot = s.os;
         timer_interrupt_clear = s.clr; timer_count = s.cnt;
         @(posedge clk); #1;
         n_checks++;
         if ({irq, run, val} !== {s.irq, s.run, s.val}) begin
            n_fail++;
            $display("FAIL max_count step %0d: irq/run/value got %b/%b/%h expected %b/%b/%h",
                     k, irq, run, val, s.irq, s.run, s.val);
         end
         k++;
      end
   endtask

   // Checks the PRESCALE=3 instance: the value moves only every third RUN clock
   // and expiry lands 6 clocks after RUN is entered.
   task automatic test_prescale();
      step_t s;
      int k = 0;
      push(1,0,0,0,2,  0,0,0);
      push(0,1,1,0,2,  0,0,0);
      push(0,1,1,0,2,  0,1,2);
      push(0,1,1,0,2,  0,1,2);
      push(0,1,1,0,2,  0,1,2);
      push(0,1,1,0,2,  0,1,1);
      push(0,1,1,0,2,  0,1,1);
      push(0,1,1,0,2,  0,1,1);
      push(0,1,1,0,2,  1,0,0);
      push(0,0,1,0,2,  1,0,0);
      push(0,0,1,1,2,  0,0,0);
      while (q.size() > 0) begin
         s = q.pop_front();
         reset = s.rst; timer_enable = s.en; timer_one_shot = s.os;
         timer_interrupt_clear = s.clr; timer_count = s.cnt;
         @(posedge clk); #1;
         n_checks++;
         if ({p_irq, p_run, p_val} !== {s.irq, s.run, s.val}) begin
            n_fail++;
            $display("FAIL prescale step %0d: irq/run/value got %b/%b/%h expected %b/%b/%h",
                     k, p_irq, p_run, p_val, s.irq, s.run, s.val);
         end
         k++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_one_shot();
      test_periodic();
      test_zero_count();
      test_max_count();
      test_prescale();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
